// File: rtl/gpio_pkg.sv
// Shared constants for the edge-capture GPIO block: register word addresses
// and the reset values of the edge-enable registers.
package gpio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_MASK    = 3'd2;
    localparam logic [2:0] ADDR_CAPTURE = 3'd3;
    localparam logic [2:0] ADDR_RISE    = 3'd4;
    localparam logic [2:0] ADDR_FALL    = 3'd5;
    localparam logic [2:0] ADDR_LIMIT   = 3'd6;
    localparam logic [2:0] ADDR_STATUS  = 3'd7;

    // Rising edges enabled out of reset so the block powers up like the old PIO.
    localparam logic [31:0] RISE_EN_RST = 32'hFFFF_FFFF;
    localparam logic [31:0] FALL_EN_RST = 32'h0000_0000;

endpackage

// File: rtl/gpio_edge_irq_if.sv
// Avalon-MM slave bus plus the level interrupt line of the GPIO block.
interface gpio_edge_irq_if;
    import gpio_pkg::*;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/gpio_debounce.sv
// One input channel: metastability synchroniser, debounce counter and the
// debounced level. ev_rise/ev_fall pulse in the cycle the stable level flips.
module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_raw,
    input  logic [DEBOUNCE_W-1:0] limit,
    output logic                  stable,
    output logic                  ev_rise,
    output logic                  ev_fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DEBOUNCE_W-1:0]  cnt;
    logic                   sync;
    logic                   commit;

    assign sync   = sync_q[SYNC_STAGES-1];
    // The count is compared against the live limit, so a limit write also
    // affects a debounce already in progress.
    assign commit = (sync != stable) && (cnt >= limit);

    assign ev_rise = commit & sync;
    assign ev_fall = commit & ~sync;

    // Shift the raw input through the synchroniser chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_raw};
        end
    end

    // Count cycles of disagreement; accept the new level once the count reaches the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync != stable) begin
            if (commit) begin
                stable <= sync;
                cnt    <= '0;
            end else if (cnt != {DEBOUNCE_W{1'b1}}) begin
                cnt <= cnt + DEBOUNCE_W'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/gpio_edge_irq.sv
// Edge-capture GPIO peripheral: per-channel debounce, selectable rise/fall
// capture with write-1-to-clear, interrupt mask and a registered read port.
module gpio_edge_irq
    import gpio_pkg::*;
#(
    parameter int          WIDTH         = 4,
    parameter int          SYNC_STAGES   = 2,
    parameter int          DEBOUNCE_W    = 16,
    parameter int unsigned DEBOUNCE_INIT = 0
) (
    input  logic             clk,
    input  logic             reset,
    gpio_edge_irq_if.slave   bus,
    input  logic [WIDTH-1:0] in_port
);

    logic [WIDTH-1:0]      stable;
    logic [WIDTH-1:0]      ev_rise;
    logic [WIDTH-1:0]      ev_fall;
    logic [WIDTH-1:0]      ev;
    logic [WIDTH-1:0]      clr;
    logic [WIDTH-1:0]      mask;
    logic [WIDTH-1:0]      capture;
    logic [WIDTH-1:0]      rise_en;
    logic [WIDTH-1:0]      fall_en;
    logic [DEBOUNCE_W-1:0] limit;
    logic [31:0]           rd_mux;
    logic                  wr;
    logic                  irq_int;
    logic                  unused_wdata;

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        gpio_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_W  (DEBOUNCE_W)
        ) u_debounce (
            .clk     (clk),
            .reset   (reset),
            .in_raw  (in_port[g]),
            .limit   (limit),
            .stable  (stable[g]),
            .ev_rise (ev_rise[g]),
            .ev_fall (ev_fall[g])
        );
    end

    assign wr      = bus.chipselect & ~bus.write_n;
    assign ev      = (ev_rise & rise_en) | (ev_fall & fall_en);
    assign clr     = (wr && bus.address == ADDR_CAPTURE) ? bus.writedata[WIDTH-1:0] : '0;
    assign irq_int = |(capture & mask);
    assign bus.irq = irq_int;

    // Write data bits above the widest register have no destination.
    assign unused_wdata = ^bus.writedata;

    // Register file writes; the clear is applied before OR-ing in new events so none is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask    <= '0;
            capture <= '0;
            rise_en <= RISE_EN_RST[WIDTH-1:0];
            fall_en <= FALL_EN_RST[WIDTH-1:0];
            limit   <= DEBOUNCE_W'(DEBOUNCE_INIT);
        end else begin
            capture <= (capture & ~clr) | ev;
            if (wr) begin
                case (bus.address)
                    ADDR_MASK:  mask    <= bus.writedata[WIDTH-1:0];
                    ADDR_RISE:  rise_en <= bus.writedata[WIDTH-1:0];
                    ADDR_FALL:  fall_en <= bus.writedata[WIDTH-1:0];
                    ADDR_LIMIT: limit   <= bus.writedata[DEBOUNCE_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Read mux on the current address, regardless of chipselect.
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:    rd_mux[WIDTH-1:0]      = stable;
            ADDR_MASK:    rd_mux[WIDTH-1:0]      = mask;
            ADDR_CAPTURE: rd_mux[WIDTH-1:0]      = capture;
            ADDR_RISE:    rd_mux[WIDTH-1:0]      = rise_en;
            ADDR_FALL:    rd_mux[WIDTH-1:0]      = fall_en;
            ADDR_LIMIT:   rd_mux[DEBOUNCE_W-1:0] = limit;
            ADDR_STATUS:  rd_mux[0]              = irq_int;
            default:      rd_mux                 = '0;
        endcase
    end

    // Register read data for a one-cycle read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_gpio_edge_irq.sv
// Directed scenarios plus randomized bus/input traffic, checked every cycle
// against a behavioural model of the register map and debounce rules.
module tb_gpio_edge_irq;
    import gpio_pkg::*;

    localparam int W     = 4;
    localparam int SS    = 2;
    localparam int DW    = 16;
    localparam int DINIT = 10;

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] in_port;

    gpio_edge_irq_if bus_if();

    gpio_edge_irq #(
        .WIDTH         (W),
        .SYNC_STAGES   (SS),
        .DEBOUNCE_W    (DW),
        .DEBOUNCE_INIT (DINIT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_if),
        .in_port (in_port)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    logic [W-1:0] m_stable, m_cap, m_mask, m_rise, m_fall;
    int           m_limit;
    int           m_run[W];
    logic [31:0]  m_rdata;
    logic         m_irq;
    logic [W-1:0] m_hist[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_stable = '0;
        m_cap    = '0;
        m_mask   = '0;
        m_rise   = '1;
        m_fall   = '0;
        m_limit  = DINIT;
        for (int i = 0; i < W; i++) m_run[i] = 0;
        m_rdata  = '0;
        m_irq    = 1'b0;
        m_hist.delete();
        for (int i = 0; i < SS; i++) m_hist.push_back('0);
    endtask

    // One clock edge of the model; inputs are those present at the edge.
    task automatic model_step();
        logic [W-1:0] seen, nstab, ev, clr;
        logic [31:0]  wd;
        bit           wr;
        int           addr;
        wr   = bus_if.chipselect && !bus_if.write_n;
        addr = int'(bus_if.address);
        wd   = bus_if.writedata;
        seen = m_hist[SS-1];
        nstab = m_stable;
        ev    = '0;
        // A channel's level is accepted once it has disagreed for more than limit cycles.
        for (int i = 0; i < W; i++) begin
            if (seen[i] == m_stable[i]) m_run[i] = 0;
            else begin
                m_run[i]++;
                if (m_run[i] > m_limit) begin
                    nstab[i] = seen[i];
                    m_run[i] = 0;
                    ev[i] = seen[i] ? m_rise[i] : m_fall[i];
                end
            end
        end
        case (addr)
            0: m_rdata = 32'(m_stable);
            2: m_rdata = 32'(m_mask);
            3: m_rdata = 32'(m_cap);
            4: m_rdata = 32'(m_rise);
            5: m_rdata = 32'(m_fall);
            6: m_rdata = 32'(m_limit);
            7: m_rdata = 32'(m_irq);
            default: m_rdata = '0;
        endcase
        clr = '0;
        if (wr) begin
            case (addr)
                2: m_mask  = wd[W-1:0];
                3: clr     = wd[W-1:0];
                4: m_rise  = wd[W-1:0];
                5: m_fall  = wd[W-1:0];
                6: m_limit = int'(wd[DW-1:0]);
                default: ;
            endcase
        end
        m_cap    = (m_cap & ~clr) | ev;
        m_stable = nstab;
        m_hist.push_front(in_port);
        void'(m_hist.pop_back());
        m_irq = |(m_cap & m_mask);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("readdata", bus_if.readdata, m_rdata);
        chk("irq", 32'(bus_if.irq), 32'(m_irq));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic idle();
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.address    = 3'd0;
        bus_if.writedata  = '0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        bus_if.address    = a;
        bus_if.writedata  = d;
        tick();
        idle();
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b1;
        bus_if.address    = a;
        tick();
        d = bus_if.readdata;
        idle();
    endtask

    // Asserts reset between edges, checks the asynchronous clear, releases after two edges.
    task automatic do_reset();
        reset = 1'b1;
        #2;
        model_reset();
        chk("rst_readdata", bus_if.readdata, 32'h0);
        chk("rst_irq", 32'(bus_if.irq), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [31:0] v;

    initial begin
        in_port = '0;
        idle();
        model_reset();
        reset = 1'b1;
        @(posedge clk);
        #2;
        chk("por_readdata", bus_if.readdata, 32'h0);
        chk("por_irq", 32'(bus_if.irq), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        rd(ADDR_LIMIT, v);   chk("por_limit", v, 32'd10);
        rd(ADDR_RISE, v);    chk("por_rise", v, 32'hF);

        // Defaults with limit 0
        wr(ADDR_LIMIT, 32'd0);
        in_port = 4'b0010;
        ticks(2);
        rd(ADDR_CAPTURE, v); chk("t1_cap_early", v, 32'h0);
        rd(ADDR_CAPTURE, v); chk("t1_cap", v, 32'h2);
        chk("t1_irq_masked", 32'(bus_if.irq), 32'h0);
        wr(ADDR_MASK, 32'h2);
        chk("t1_irq_set", 32'(bus_if.irq), 32'h1);
        wr(ADDR_CAPTURE, 32'h2);
        chk("t1_irq_clr", 32'(bus_if.irq), 32'h0);
        rd(ADDR_CAPTURE, v); chk("t1_cap_clr", v, 32'h0);

        // Debounce: short glitch rejected, held level accepted after 2+3+1 edges
        wr(ADDR_LIMIT, 32'd3);
        in_port = 4'b0011;
        ticks(3);
        in_port = 4'b0010;
        ticks(8);
        rd(ADDR_CAPTURE, v); chk("t2_glitch_cap", v, 32'h0);
        rd(ADDR_DATA, v);    chk("t2_glitch_data", v, 32'h2);
        in_port = 4'b0011;
        ticks(5);
        rd(ADDR_CAPTURE, v); chk("t2_cap_edge5", v, 32'h0);
        rd(ADDR_CAPTURE, v); chk("t2_cap_edge6", v, 32'h1);
        rd(ADDR_DATA, v);    chk("t2_data", v, 32'h3);
        wr(ADDR_CAPTURE, 32'h1);

        // Edge select: falling only on bit2
        wr(ADDR_RISE, 32'h0);
        wr(ADDR_FALL, 32'h4);
        in_port = 4'b0111;
        ticks(10);
        rd(ADDR_CAPTURE, v); chk("t3_rise_off", v, 32'h0);
        in_port = 4'b0011;
        ticks(10);
        rd(ADDR_CAPTURE, v); chk("t3_fall_on", v, 32'h4);
        wr(ADDR_CAPTURE, 32'h4);

        // Clear racing a new event on the same bit
        wr(ADDR_LIMIT, 32'd0);
        wr(ADDR_RISE, 32'h1);
        wr(ADDR_FALL, 32'h0);
        wr(ADDR_MASK, 32'h1);
        in_port = 4'b0010;
        ticks(5);
        in_port = 4'b0011;
        ticks(2);
        wr(ADDR_CAPTURE, 32'h1);
        chk("t4_race_irq", 32'(bus_if.irq), 32'h1);
        rd(ADDR_CAPTURE, v); chk("t4_race_cap", v, 32'h1);
        wr(ADDR_CAPTURE, 32'h1);
        chk("t4_irq_drop", 32'(bus_if.irq), 32'h0);

        // Readback and ignored writes
        wr(ADDR_LIMIT, 32'hFFFF_FFFF);
        rd(ADDR_LIMIT, v);   chk("t5_limit", v, 32'h0000_FFFF);
        rd(3'd1, v);         chk("t5_addr1", v, 32'h0);
        rd(ADDR_STATUS, v);  chk("t5_status", v, 32'h0);
        wr(ADDR_DATA, 32'hFFFF_FFFF);
        rd(ADDR_DATA, v);    chk("t5_data_ro", v, 32'h3);

        // Reset in the middle of a debounce
        wr(ADDR_LIMIT, 32'd10);
        wr(ADDR_RISE, 32'hF);
        in_port = 4'b1011;
        ticks(7);
        do_reset();
        rd(ADDR_DATA, v);    chk("t6_data", v, 32'h0);
        rd(ADDR_MASK, v);    chk("t6_mask", v, 32'h0);
        rd(ADDR_CAPTURE, v); chk("t6_cap", v, 32'h0);
        rd(ADDR_RISE, v);    chk("t6_rise", v, 32'hF);
        rd(ADDR_FALL, v);    chk("t6_fall", v, 32'h0);
        rd(ADDR_LIMIT, v);   chk("t6_limit", v, 32'd10);
        ticks(6);
        rd(ADDR_CAPTURE, v); chk("t6_cap_edge13", v, 32'h0);
        rd(ADDR_CAPTURE, v); chk("t6_cap_edge14", v, 32'hB);
        wr(ADDR_CAPTURE, 32'hF);
        ticks(20);
        rd(ADDR_CAPTURE, v); chk("t6_single", v, 32'h0);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) < 10)
                in_port = in_port ^ W'(1 << $urandom_range(0, W - 1));
            bus_if.address    = 3'($urandom_range(0, 7));
            bus_if.chipselect = 1'($urandom_range(0, 1));
            bus_if.write_n    = ($urandom_range(0, 3) != 0);
            bus_if.writedata  = (bus_if.address == ADDR_LIMIT) ? 32'($urandom_range(0, 6)) : $urandom;
            if ($urandom_range(0, 999) == 0) do_reset();
            else tick();
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
